// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

  // Quotient reported for a zero divisor; sliced to the unit width.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational conditional negate: absolute value on the way in, sign fix on the way out.
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  // Two's complement negate when requested, pass-through otherwise.
  always_comb begin
    out_o = neg_i ? ('0 - in_i) : in_i;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add / restoring-subtract step per clock; start/busy/done handshake.
// Optional signed MULT/DIV support is enabled by defining MDU_SIGNED_EN.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  mdu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            div0_q, div0_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic [W-1:0]    mag_a, mag_b;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix, rem_fix;

  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      rem_sh, div_diff;
  logic [2*W-1:0]  div_next;

`ifdef MDU_SIGNED_EN
  logic sgn_op, accept, neg_q, rem_neg_q;

  assign sgn_op = op[1];
  assign accept = start && (state_q != S_RUN);

  mdu_sign_fix #(.W(W)) u_abs_a (
    .in_i(operand_A), .neg_i(sgn_op & operand_A[W-1]), .out_o(mag_a));
  mdu_sign_fix #(.W(W)) u_abs_b (
    .in_i(operand_B), .neg_i(sgn_op & operand_B[W-1]), .out_o(mag_b));
  mdu_sign_fix #(.W(2*W)) u_fix_prod (
    .in_i(acc_q), .neg_i(neg_q), .out_o(prod_fix));
  mdu_sign_fix #(.W(W)) u_fix_quot (
    .in_i(acc_q[W-1:0]), .neg_i(neg_q), .out_o(quot_fix));
  mdu_sign_fix #(.W(W)) u_fix_rem (
    .in_i(acc_q[2*W-1:W]), .neg_i(rem_neg_q), .out_o(rem_fix));

  // Result signs captured with the operands; applied only at commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (accept) begin
      neg_q     <= sgn_op & (operand_A[W-1] ^ operand_B[W-1]);
      rem_neg_q <= sgn_op & operand_A[W-1];
    end
  end
`else
  logic unused_op_sign;

  assign unused_op_sign = op[1];
  assign mag_a    = operand_A;
  assign mag_b    = operand_B;
  assign prod_fix = acc_q;
  assign quot_fix = acc_q[W-1:0];
  assign rem_fix  = acc_q[2*W-1:W];
`endif

  // One iteration of each algorithm on the shared {upper,lower} accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};
    rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff = rem_sh - {1'b0, opb_q};
    div_next = div_diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                           : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
  end

  // Next-state, iteration and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_RUN: begin
        if (cnt_q == CW'(W)) begin
          state_d = S_DONE;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = div0_q ? DIV0_QUOTIENT[W-1:0] : quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (hi_we) hi_d = wr_data;
        if (lo_we) lo_d = wr_data;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          case (op)
            OP_MULTU, OP_MULT: is_div_d = 1'b0;
            OP_DIVU, OP_DIV:   is_div_d = 1'b1;
            default:           is_div_d = 1'b0;
          endcase
          div0_d = (operand_B == '0);
          // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
          opb_d  = op[0] ? mag_b : mag_a;
          acc_d  = {{W{1'b0}}, (op[0] ? mag_a : mag_b)};
        end
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit with an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we, busy, done;
  logic [1:0]  op;
  logic [31:0] operand_A, operand_B, wr_data, HI, LO;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_A(operand_A), .operand_B(operand_B),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .HI(HI), .LO(LO));

  // Reference result {HI,LO} from plain arithmetic.
  function automatic logic [63:0] ref_mdu(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    longint sa, sb, q, rm;
    logic [63:0] r;
`ifdef MDU_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o[0]) begin
      if (sgn) r = sa * sb;
      else     r = {32'b0, a} * {32'b0, b};
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (sgn) begin
      q  = sa / sb;
      rm = sa % sb;
      r  = {rm[31:0], q[31:0]};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  // Drive one operation and wait (bounded) for done; returns latency and busy-high count.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output int bcyc, output logic [31:0] h, output logic [31:0] l);
    cyc = 0;
    bcyc = 0;
    @(negedge clk);
    op = o; operand_A = a; operand_B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; operand_A = $urandom; operand_B = $urandom;
    if (busy) bcyc++;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      if (busy) bcyc++;
    end
    h = HI;
    l = LO;
  endtask

  task automatic test_reset;
    vectors++;
    if ({HI, LO, busy, done} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_state: HI=%h LO=%h busy=%b done=%b, required all zero", HI, LO, busy, done);
    end
  endtask

  task automatic test_multu_max;
    int cyc, bcyc;
    logic [31:0] h, l;
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcyc, h, l);
    vectors++;
    if (cyc !== 33) begin miscompares++; $display("FAIL multu_latency: got %0d required 33", cyc); end
    vectors++;
    if (bcyc !== 33) begin miscompares++; $display("FAIL multu_busy_cycles: got %0d required 33", bcyc); end
    vectors++;
    if ({h, l} !== 64'hFFFF_FFFE_0000_0001) begin
      miscompares++; $display("FAIL multu_max: got %h_%h required fffffffe_00000001", h, l);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL done_pulse_width: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc;
    logic [31:0] h, l;
    do_op(2'b01, 32'd100, 32'd7, cyc, bcyc, h, l);
    vectors++;
    if ({h, l} !== {32'd2, 32'd14}) begin
      miscompares++; $display("FAIL divu_100_7: got HI=%0d LO=%0d required HI=2 LO=14", h, l);
    end
    do_op(2'b01, 32'd5, 32'd0, cyc, bcyc, h, l);
    vectors++;
    if (cyc !== 33) begin miscompares++; $display("FAIL b2b_latency: got %0d required 33", cyc); end
    vectors++;
    if ({h, l} !== {32'd5, 32'hFFFF_FFFF}) begin
      miscompares++; $display("FAIL divu_by_zero: got %h_%h required 00000005_ffffffff", h, l);
    end
  endtask

  task automatic test_ignored_start;
    int first_done, n_done;
    first_done = -1;
    n_done = 0;
    @(negedge clk);
    op = 2'b00; operand_A = 32'd3; operand_B = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) begin
        operand_A = 32'd9; operand_B = 32'd9; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
    end
    vectors++;
    if (n_done !== 1 || first_done !== 33) begin
      miscompares++; $display("FAIL ignored_start_done: %0d pulses at %0d, required 1 at 33", n_done, first_done);
    end
    vectors++;
    if ({HI, LO} !== {32'd0, 32'd12} || busy !== 1'b0) begin
      miscompares++; $display("FAIL ignored_start_result: HI=%0d LO=%0d busy=%b required 0 12 0", HI, LO, busy);
    end
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] h_before;
    int cyc;
    @(negedge clk);
    op = 2'b00; operand_A = 32'd2; operand_B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    h_before = HI;
    repeat (4) @(posedge clk);
    @(negedge clk);
    hi_we = 1'b1; wr_data = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    vectors++;
    if (HI !== h_before) begin
      miscompares++; $display("FAIL mthi_while_busy: HI=%h required %h", HI, h_before);
    end
    cyc = 0;
    while (!done && cyc < 60) begin @(posedge clk); #1; cyc++; end
    vectors++;
    if (!done || {HI, LO} !== {32'd0, 32'd6}) begin
      miscompares++; $display("FAIL mt_op_result: done=%b HI=%h LO=%h required 1 0 6", done, HI, LO);
    end
    @(negedge clk);
    lo_we = 1'b1; wr_data = 32'hABCD;
    @(posedge clk); #1;
    lo_we = 1'b0;
    vectors++;
    if (LO !== 32'hABCD || HI !== 32'd0) begin
      miscompares++; $display("FAIL mtlo_idle: HI=%h LO=%h required 0 abcd", HI, LO);
    end
    @(negedge clk);
    hi_we = 1'b1; wr_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    hi_we = 1'b0;
    vectors++;
    if (HI !== 32'h5555_AAAA || LO !== 32'hABCD) begin
      miscompares++; $display("FAIL mthi_idle: HI=%h LO=%h required 5555aaaa abcd", HI, LO);
    end
  endtask

  task automatic test_signed;
    int cyc, bcyc;
    logic [31:0] h, l;
`ifdef MDU_SIGNED_EN
    do_op(2'b11, -32'sd7, 32'd2, cyc, bcyc, h, l);
    vectors++;
    if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      miscompares++; $display("FAIL div_neg7_2: got %h_%h required ffffffff_fffffffd", h, l);
    end
    do_op(2'b10, -32'sd3, 32'd4, cyc, bcyc, h, l);
    vectors++;
    if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFF4) begin
      miscompares++; $display("FAIL mult_neg3_4: got %h_%h required ffffffff_fffffff4", h, l);
    end
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcyc, h, l);
    vectors++;
    if ({h, l} !== 64'h0000_0000_8000_0000) begin
      miscompares++; $display("FAIL div_minneg_m1: got %h_%h required 00000000_80000000", h, l);
    end
`else
    do_op(2'b10, -32'sd3, 32'd4, cyc, bcyc, h, l);
    vectors++;
    if ({h, l} !== 64'h0000_0003_FFFF_FFF4) begin
      miscompares++; $display("FAIL op10_unsigned: got %h_%h required 00000003_fffffff4", h, l);
    end
`endif
  endtask

  task automatic test_random;
    int cyc, bcyc;
    logic [31:0] h, l, a, b;
    logic [1:0] o;
    logic [63:0] exp_r;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      exp_r = ref_mdu(o, a, b);
      do_op(o, a, b, cyc, bcyc, h, l);
      vectors++;
      if ({h, l} !== exp_r || cyc !== 33) begin
        miscompares++;
        $display("FAIL random_%0d: op=%b a=%h b=%h got %h_%h lat %0d required %h_%h lat 33",
                 i, o, a, b, h, l, cyc, exp_r[63:32], exp_r[31:0]);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    int n_done;
    n_done = 0;
    @(negedge clk);
    op = 2'b00; operand_A = 32'hDEAD_BEEF; operand_B = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({HI, LO, busy, done} !== 66'd0) begin
      miscompares++; $display("FAIL reset_mid_op: HI=%h LO=%h busy=%b done=%b required all zero", HI, LO, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    vectors++;
    if (n_done !== 0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_abort: %0d done pulses busy=%b required 0 0", n_done, busy);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; operand_A = '0; operand_B = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    test_multu_max;
    test_back_to_back;
    test_ignored_start;
    test_mthi_mtlo;
    test_signed;
    test_random;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
